// File: rtl/host_bus_pkg.sv
// Shared types and constants for the host bus master.
// Opcodes, FSM encoding and default response bytes.
package host_bus_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam logic [7:0] ACK_BYTE_DEF    = 8'hA5;
    localparam logic [7:0] ERR_TIMEOUT_DEF = 8'hEE;
    localparam logic [7:0] ERR_OPCODE_DEF  = 8'hEF;
    localparam int         TIMEOUT_DEF     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_e;

    function automatic logic [31:0] put_byte(
        input logic [31:0] w,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/host_bus_master.sv
// Host-driven bus initiator fed by UART command frames.
// Assembles a frame, issues one 32-bit access, returns status/data.
module host_bus_master
    import host_bus_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_TIMEOUT    = ERR_TIMEOUT_DEF,
    parameter logic [7:0] ERR_OPCODE     = ERR_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic          op_wr_q, op_wr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    resp_cnt_q, resp_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_ready_q, rx_ready_d;
    logic          tx_valid_q, tx_valid_d;
    logic          mem_valid_q, mem_valid_d;
    logic          rx_fire;
    logic          tx_fire;

    assign rx_fire = rx_valid && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready;

    // Next-state, frame assembly, bus wait and response shifting.
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_fire) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        op_wr_d    = (rx_data == OP_WRITE);
                        byte_cnt_d = 2'd0;
                        state_d    = ST_ADDR;
                    end else begin
                        resp_d     = {24'h0, ERR_OPCODE};
                        resp_cnt_d = 2'd0;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    addr_d     = put_byte(addr_q, byte_cnt_q, rx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        tmo_d      = '0;
                        state_d    = op_wr_q ? ST_DATA : ST_BUS;
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    wdata_d    = put_byte(wdata_q, byte_cnt_q, rx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        tmo_d      = '0;
                        state_d    = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    resp_d     = op_wr_q ? {24'h0, ACK_BYTE} : mem_rdata;
                    resp_cnt_d = op_wr_q ? 2'd0 : 2'd3;
                    state_d    = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    resp_d     = {24'h0, ERR_TIMEOUT};
                    resp_cnt_d = 2'd0;
                    state_d    = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    if (resp_cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        resp_d     = resp_q >> 8;
                        resp_cnt_d = resp_cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rx_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                      (state_d == ST_DATA);
        tx_valid_d  = (state_d == ST_RESP);
        mem_valid_d = (state_d == ST_BUS);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_q      <= 32'h0;
            resp_cnt_q  <= 2'd0;
            tmo_q       <= '0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_cnt_q  <= resp_cnt_d;
            tmo_q       <= tmo_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = resp_q[7:0];
    assign mem_valid = mem_valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = (mem_valid_q && op_wr_q) ? 4'hf : 4'h0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_host_bus_master.sv
// Scoreboard bench for host_bus_master.
// Expected bus accesses and tx bytes are queued, monitors compare.
module tb_host_bus_master;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [7:0]  exp_tx[$];
    mem_exp_t    cur;

    int vectors     = 0;
    int miscompares = 0;
    int ready_delay = -1;
    logic [31:0] rdata_cfg = 32'h0;
    int vcnt     = 0;
    int pulses   = 0;
    int hi_len   = 0;
    int last_len = 0;
    logic mv_prev = 1'b0;

    host_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: raise mem_ready for one cycle after ready_delay cycles.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            vcnt = 0;
        end else if (mem_valid) begin
            vcnt++;
            if (ready_delay >= 0 && vcnt >= ready_delay) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_cfg;
            end
        end else begin
            vcnt = 0;
        end
    end

    // Bus monitor: pop on request start, check stability while held.
    always @(negedge clk) begin
        if (mem_valid) begin
            if (!mv_prev) begin
                pulses++;
                hi_len = 0;
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected", mem_addr, ~mem_addr);
                    cur = '{a: mem_addr, d: mem_wdata, s: mem_wstrb};
                end else begin
                    cur = exp_mem.pop_front();
                end
            end
            hi_len++;
            check("mem_addr", mem_addr, cur.a);
            check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, cur.s});
            check("mem_instr", {31'h0, mem_instr}, 32'h0);
            if (cur.s != 4'h0) check("mem_wdata", mem_wdata, cur.d);
        end else if (mv_prev) begin
            last_len = hi_len;
        end
        mv_prev = mem_valid;
    end

    // Transmit monitor: pop on every accepted byte.
    always @(negedge clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0)
                check("tx_unexpected", {24'h0, tx_data}, 32'h100);
            else
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_stall: rx_ready low for %0d cycles, needed 1", n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_tx.size() != 0 || exp_mem.size() != 0)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, needed 0",
                     name, busy, n);
        end
        check({name, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
        check({name, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        check({name, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({name, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
        check({name, "_mem_addr"}, mem_addr, 32'h0);
        check({name, "_mem_wdata"}, mem_wdata, 32'h0);
        check({name, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
        check({name, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Write frame, ready after 3 cycles
        ready_delay = 3;
        p0 = pulses;
        exp_mem.push_back('{a: 32'h4000_0000, d: 32'hDEAD_BEEF, s: 4'hf});
        exp_tx.push_back(8'hA5);
        send_byte(8'h01);
        send_word(32'h4000_0000);
        send_word(32'hDEAD_BEEF);
        wait_idle("wr1");
        check("wr1_pulses", pulses - p0, 1);

        // Read frame, ready after 1 cycle
        ready_delay = 1;
        rdata_cfg   = 32'h1234_5678;
        exp_mem.push_back('{a: 32'hC300_0004, d: 32'h0, s: 4'h0});
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        send_byte(8'h02);
        send_word(32'hC300_0004);
        wait_idle("rd1");

        // Bad opcode, then a normal read
        p0 = pulses;
        exp_tx.push_back(8'hEF);
        send_byte(8'h7F);
        wait_idle("badop");
        check("badop_pulses", pulses - p0, 0);
        ready_delay = 2;
        rdata_cfg   = 32'hA1B2_C3D4;
        exp_mem.push_back('{a: 32'h0000_0000, d: 32'h0, s: 4'h0});
        exp_tx.push_back(8'hD4);
        exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'hB2);
        exp_tx.push_back(8'hA1);
        send_byte(8'h02);
        send_word(32'h0000_0000);
        wait_idle("rd2");

        // Timeout: no mem_ready
        ready_delay = -1;
        exp_mem.push_back('{a: 32'h8000_0010, d: 32'h0, s: 4'h0});
        exp_tx.push_back(8'hEE);
        send_byte(8'h02);
        send_word(32'h8000_0010);
        wait_idle("tmo");
        check("tmo_len", last_len, 16);

        // Back-pressure on read response
        ready_delay = 1;
        rdata_cfg   = 32'h1234_5678;
        tx_ready    = 1'b0;
        exp_mem.push_back('{a: 32'h0000_0008, d: 32'h0, s: 4'h0});
        exp_tx.push_back(8'h78);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        send_byte(8'h02);
        send_word(32'h0000_0008);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_tx_valid", {31'h0, tx_valid}, 32'h1);
            check("hold_tx_data", {24'h0, tx_data}, 32'h78);
            check("hold_rx_ready", {31'h0, rx_ready}, 32'h0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        wait_idle("hold");

        // Reset after 3 address bytes, then a full write
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        reset_n = 1'b1;
        @(negedge clk);
        ready_delay = 2;
        p0 = pulses;
        exp_mem.push_back('{a: 32'h1000_0020, d: 32'h1122_3344, s: 4'hf});
        exp_tx.push_back(8'hA5);
        send_byte(8'h01);
        send_word(32'h1000_0020);
        send_word(32'h1122_3344);
        wait_idle("wr2");
        check("wr2_pulses", pulses - p0, 1);

        repeat (3) @(negedge clk);
        check("txq_empty", exp_tx.size(), 0);
        check("memq_empty", exp_mem.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
